// File: rtl/amiga_trigger_tx_ctrl.sv
// amiga_trigger_tx_ctrl
// ---------------------
// Frame sequencer for the AMIGA trigger serial link. A trigger word taken
// over a valid/ready handshake is sent as one frame:
//   preamble ('1' bits), start bit ('0'), data MSB first, even parity,
// followed by an idle gap. The block drives the data / bit-clock / enable
// inputs of a purely combinational Manchester encoder, so every line
// timing decision lives here.
//
// Ports:
//   clock      system clock, rising edge
//   reset      synchronous, active-high
//   in_data    trigger word (DATA_WIDTH bits)
//   in_valid   in_data valid
//   in_ready   block can accept a word
//   abort      synchronous frame abort (ignored while idle)
//   tx_data    encoder DataIn, changes only at bit boundaries
//   tx_bitclk  encoder clock, 0 for the first half of a bit, 1 for the second
//   tx_enable  encoder enable, high for the line part of the frame
//   busy       frame or gap in progress
//   frame_done one-cycle pulse on the last cycle of the parity bit
module amiga_trigger_tx_ctrl #(
  parameter int DATA_WIDTH    = 16,
  parameter int HALF_PERIOD   = 4,
  parameter int PREAMBLE_BITS = 4,
  parameter int GAP_BITS      = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  abort,
  output logic                  tx_data,
  output logic                  tx_bitclk,
  output logic                  tx_enable,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int MAXB0 = (DATA_WIDTH > PREAMBLE_BITS) ? DATA_WIDTH : PREAMBLE_BITS;
  localparam int MAXB1 = (MAXB0 > GAP_BITS) ? MAXB0 : GAP_BITS;
  localparam int MAXB  = (MAXB1 > 1) ? MAXB1 : 1;
  localparam int HW    = $clog2(HALF_PERIOD) + 1;
  localparam int BW    = $clog2(MAXB) + 1;

  localparam logic [HW-1:0] HP_LAST = HW'(HALF_PERIOD - 1);
  // Position of the second-to-last cycle of a bit: frame_done is raised
  // there so that the registered pulse lands on the final parity cycle.
  localparam logic [HW-1:0] HP_PEN    = HW'((HALF_PERIOD > 1) ? HALF_PERIOD - 2 : 0);
  localparam logic          PEN_PHASE = (HALF_PERIOD > 1);

  localparam logic [BW-1:0] PB_LAST = BW'((PREAMBLE_BITS > 0) ? PREAMBLE_BITS - 1 : 0);
  localparam logic [BW-1:0] DW_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] GB_LAST = BW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  typedef enum logic [2:0] {IDLE, PREAMBLE, START, DATA, PARITY, GAP} state_t;

  state_t                  state_reg;
  logic [HW-1:0]           half_reg;    // cycle within the current half bit
  logic                    phase_reg;   // 0 = first half of bit, 1 = second
  logic [BW-1:0]           bit_reg;     // bit index within multi-bit states
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic                    parity_reg;

  logic half_last;
  logic bit_end;

  assign half_last = (half_reg == HP_LAST);
  assign bit_end   = half_last && phase_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      half_reg   <= '0;
      phase_reg  <= 1'b0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      parity_reg <= 1'b0;
      in_ready   <= 1'b0;
      tx_data    <= 1'b0;
      tx_bitclk  <= 1'b0;
      tx_enable  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state_reg == IDLE) begin
        in_ready  <= 1'b1;
        busy      <= 1'b0;
        tx_data   <= 1'b0;
        tx_bitclk <= 1'b0;
        tx_enable <= 1'b0;
        // abort blocks a simultaneous accept
        if (in_valid && in_ready && !abort) begin
          shift_reg  <= in_data;
          parity_reg <= ^in_data;
          in_ready   <= 1'b0;
          busy       <= 1'b1;
          tx_enable  <= 1'b1;
          half_reg   <= '0;
          phase_reg  <= 1'b0;
          bit_reg    <= '0;
          if (PREAMBLE_BITS > 0) begin
            state_reg <= PREAMBLE;
            tx_data   <= 1'b1;
          end else begin
            state_reg <= START;
            tx_data   <= 1'b0;
          end
        end
      end else if (abort) begin
        state_reg <= IDLE;
        half_reg  <= '0;
        phase_reg <= 1'b0;
        bit_reg   <= '0;
        in_ready  <= 1'b1;
        busy      <= 1'b0;
        tx_data   <= 1'b0;
        tx_bitclk <= 1'b0;
        tx_enable <= 1'b0;
      end else begin
        // Half-bit timing runs in the gap too, it just stays off the line.
        if (half_last) begin
          half_reg  <= '0;
          phase_reg <= ~phase_reg;
        end else begin
          half_reg <= half_reg + HW'(1);
        end
        tx_bitclk <= (state_reg != GAP) && (half_last ? ~phase_reg : phase_reg);

        if (state_reg == PARITY && phase_reg == PEN_PHASE && half_reg == HP_PEN)
          frame_done <= 1'b1;

        if (bit_end) begin
          case (state_reg)
            PREAMBLE: begin
              if (bit_reg == PB_LAST) begin
                state_reg <= START;
                tx_data   <= 1'b0;
                bit_reg   <= '0;
              end else begin
                bit_reg <= bit_reg + BW'(1);
              end
            end
            START: begin
              state_reg <= DATA;
              tx_data   <= shift_reg[DATA_WIDTH-1];
              shift_reg <= shift_reg << 1;
              bit_reg   <= '0;
            end
            DATA: begin
              if (bit_reg == DW_LAST) begin
                state_reg <= PARITY;
                tx_data   <= parity_reg;
              end else begin
                bit_reg   <= bit_reg + BW'(1);
                tx_data   <= shift_reg[DATA_WIDTH-1];
                shift_reg <= shift_reg << 1;
              end
            end
            PARITY: begin
              tx_data   <= 1'b0;
              tx_enable <= 1'b0;
              bit_reg   <= '0;
              if (GAP_BITS == 0) begin
                state_reg <= IDLE;
                in_ready  <= 1'b1;
                busy      <= 1'b0;
              end else begin
                state_reg <= GAP;
              end
            end
            GAP: begin
              if (bit_reg == GB_LAST) begin
                state_reg <= IDLE;
                in_ready  <= 1'b1;
                busy      <= 1'b0;
              end else begin
                bit_reg <= bit_reg + BW'(1);
              end
            end
            default: state_reg <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_amiga_trigger_tx_ctrl.sv
// Directed testbench for amiga_trigger_tx_ctrl: a default-parameter instance
// plus a HALF_PERIOD=1 / no preamble / no gap / 8-bit instance.
module tb_amiga_trigger_tx_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [15:0] in_data;
  logic        in_valid, abort;
  logic        in_ready, tx_data, tx_bitclk, tx_enable, busy, frame_done;

  logic [7:0]  in_data2;
  logic        in_valid2, abort2;
  logic        in_ready2, tx_data2, tx_bitclk2, tx_enable2, busy2, frame_done2;

  int checks = 0;
  int errors = 0;

  amiga_trigger_tx_ctrl dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .abort(abort), .tx_data(tx_data), .tx_bitclk(tx_bitclk),
    .tx_enable(tx_enable), .busy(busy), .frame_done(frame_done)
  );

  amiga_trigger_tx_ctrl #(
    .DATA_WIDTH(8), .HALF_PERIOD(1), .PREAMBLE_BITS(0), .GAP_BITS(0)
  ) dut2 (
    .clock(clock), .reset(reset), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .abort(abort2), .tx_data(tx_data2), .tx_bitclk(tx_bitclk2),
    .tx_enable(tx_enable2), .busy(busy2), .frame_done(frame_done2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // {in_ready, busy, tx_enable, tx_data, tx_bitclk, frame_done}
  function automatic logic [5:0] vec(input int sel);
    if (sel == 0) return {in_ready, busy, tx_enable, tx_data, tx_bitclk, frame_done};
    return {in_ready2, busy2, tx_enable2, tx_data2, tx_bitclk2, frame_done2};
  endfunction

  // Called at the negedge of the accept cycle (valid driven, ready high).
  // Checks every cycle of the line, the gap, and the first idle cycle.
  task automatic run_frame(input int sel, input logic [63:0] bits, input int nbits,
                           input int hp, input int gap_bits, input bit churn,
                           input int probe_bit);
    int line, total, b, w;
    logic ed, ec, enc;
    logic [5:0] ev;
    line  = nbits * 2 * hp;
    total = line + gap_bits * 2 * hp;
    for (int t = 1; t <= total + 1; t++) begin
      @(negedge clock);
      if (t <= line) begin
        b  = (t - 1) / (2 * hp);
        w  = (t - 1) % (2 * hp);
        ed = bits[nbits - 1 - b];
        ec = (w >= hp);
        ev = {1'b0, 1'b1, 1'b1, ed, ec, (t == line)};
        if (b == probe_bit && (w == 0 || w == 2 * hp - 1)) begin
          enc = (sel == 0) ? (tx_data ^ tx_bitclk) : (tx_data2 ^ tx_bitclk2);
          check($sformatf("enc_b%0d_w%0d", b, w), {31'b0, enc}, {31'b0, ed ^ ec});
        end
      end else if (t <= total) begin
        ev = 6'b010000;
      end else begin
        ev = 6'b100000;
      end
      check($sformatf("dut%0d_t%0d", sel, t), {26'b0, vec(sel)}, {26'b0, ev});
      if (t == 1 && !churn) begin
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
      end
      if (churn && t <= total) in_data = 16'($urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    abort     = 1'b0;
    in_data2  = '0;
    in_valid2 = 1'b0;
    abort2    = 1'b0;

    // Reset held for 3 cycles: everything low
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("reset_dut0_%0d", i), {26'b0, vec(0)}, 32'h0);
      check($sformatf("reset_dut1_%0d", i), {26'b0, vec(1)}, 32'h0);
    end
    reset = 1'b0;
    @(negedge clock);
    check("release_dut0", {26'b0, vec(0)}, {26'b0, 6'b100000});
    check("release_dut1", {26'b0, vec(1)}, {26'b0, 6'b100000});

    // 16'hA5C3: parity 0 (8 ones)
    in_data  = 16'hA5C3;
    in_valid = 1'b1;
    run_frame(0, {4'b1111, 1'b0, 16'hA5C3, 1'b0}, 22, 4, 2, 1'b0, -1);

    // 16'h0001: parity 1, probe encoder output on the last data bit (index 20)
    in_data  = 16'h0001;
    in_valid = 1'b1;
    run_frame(0, {4'b1111, 1'b0, 16'h0001, 1'b1}, 22, 4, 2, 1'b0, 20);

    // Valid held with data churning while busy; 16'hBEEF has 13 ones
    in_data  = 16'hBEEF;
    in_valid = 1'b1;
    run_frame(0, {4'b1111, 1'b0, 16'hBEEF, 1'b1}, 22, 4, 2, 1'b1, -1);
    // Second word accepted the very cycle in_ready is back; 16'h1234 has 5 ones
    in_data = 16'h1234;
    run_frame(0, {4'b1111, 1'b0, 16'h1234, 1'b1}, 22, 4, 2, 1'b0, -1);

    // Abort in the middle of DATA (line cycle 60 = data bit 2)
    in_data  = 16'h5A5A;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    check("abort_pre_busy", {31'b0, busy}, 32'h1);
    repeat (59) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort_data", {26'b0, vec(0)}, {26'b0, 6'b100000});
    repeat (20) @(negedge clock);
    check("abort_data_idle", {26'b0, vec(0)}, {26'b0, 6'b100000});

    // Abort on the cycle before frame_done would pulse
    in_data  = 16'h0F0F;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (174) @(negedge clock);
    check("pre_abort_parity", {26'b0, vec(0)}, {26'b0, 6'b011010});
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort_parity", {26'b0, vec(0)}, {26'b0, 6'b100000});

    // Abort together with accept: no frame starts
    in_data  = 16'hFFFF;
    in_valid = 1'b1;
    abort    = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort_accept", {26'b0, vec(0)}, {26'b0, 6'b100000});
    @(negedge clock);
    in_valid = 1'b0;
    check("accept_after_abort", {26'b0, vec(0)}, {26'b0, 6'b011100});

    // Reset mid-frame
    repeat (30) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("reset_midframe", {26'b0, vec(0)}, 32'h0);
    reset = 1'b0;
    @(negedge clock);
    check("reset_midframe_release", {26'b0, vec(0)}, {26'b0, 6'b100000});

    // Sweep instance: 8'h80, line 0,10000000,1, frame_done at +20
    in_data2  = 8'h80;
    in_valid2 = 1'b1;
    run_frame(1, {1'b0, 8'h80, 1'b1}, 10, 1, 0, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/amiga_trigger_tx_ctrl.md
Name: amiga_trigger_tx_ctrl

Overview:
- Frame sequencer for the AMIGA trigger serial link.
- Accepts a parallel trigger word over a valid/ready handshake and serialises it as a frame: preamble, start bit, data MSB-first, even parity, inter-frame gap.
- Drives the data, bit-clock and enable inputs of the downstream Manchester encoder (encoder output = data XOR bit-clock when enabled, data otherwise).
- Owns all line timing; the encoder itself stays purely combinational.

Parameters:
DATA_WIDTH, 16, trigger word width in bits (>=1)
HALF_PERIOD, 4, system clocks per half bit (>=1); one bit = 2*HALF_PERIOD clocks
PREAMBLE_BITS, 4, number of '1' preamble bits (>=0)
GAP_BITS, 2, idle bit times after each frame before in_ready reasserts (>=0)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high
in_data  input  DATA_WIDTH  trigger word
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a word
abort  input  1  synchronous frame abort
tx_data  output  1  to encoder DataIn
tx_bitclk  output  1  to encoder clock
tx_enable  output  1  to encoder enable
busy  output  1  frame or gap in progress
frame_done  output  1  one-cycle pulse at frame completion

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high, ports named clock and reset.
- All outputs registered.
- Reset values: in_ready=0 during reset, 1 on the first cycle after reset deasserts. tx_data=0, tx_bitclk=0, tx_enable=0, busy=0, frame_done=0. State IDLE, all counters 0.
- States: IDLE, PREAMBLE, START, DATA, PARITY, GAP.
- IDLE:
  - in_ready=1, tx_enable=0, tx_data=0, tx_bitclk=0, so the line holds 0.
  - Accept when in_valid & in_ready. Latch in_data into a shift register and compute even parity (XOR of all bits).
  - Next cycle: in_ready=0, busy=1, and the first half bit starts. Go to PREAMBLE, or START if PREAMBLE_BITS=0.
- Bit timing, in every line state:
  - A half-counter counts 0..HALF_PERIOD-1.
  - tx_bitclk=0 for the first half of each bit and 1 for the second half.
  - tx_data changes only at bit boundaries, i.e. on the cycle tx_bitclk returns to 0.
- Line bits, with tx_enable=1 throughout:
  - PREAMBLE: PREAMBLE_BITS bits of tx_data=1.
  - START: one bit of tx_data=0.
  - DATA: DATA_WIDTH bits, MSB first.
  - PARITY: one bit carrying the even-parity bit.
- frame_done pulses on the last cycle of the PARITY bit.
- GAP:
  - tx_enable=0, tx_data=0, tx_bitclk=0 for GAP_BITS*2*HALF_PERIOD cycles.
  - Then IDLE with in_ready=1 and busy=0. If GAP_BITS=0, go straight to IDLE.
- Frame line duration: (PREAMBLE_BITS+DATA_WIDTH+2)*2*HALF_PERIOD cycles. Defaults: 22 bits = 176 cycles.
- Accept-to-accept minimum: 176+16+1 = 193 cycles at defaults.
- in_valid while busy: ignored, no latching; the source must hold the word until in_ready.
- abort:
  - Any non-IDLE state → IDLE on the next edge, outputs forced to idle values, no frame_done, no gap.
  - abort in IDLE has no effect.
  - abort together with accept: abort wins, no frame starts.
- reset mid-frame: same as abort, and all outputs take their reset values the next cycle.
- HALF_PERIOD=1: a bit is 2 cycles, and bitclk toggles every cycle.
- Counter widths: $clog2 of the largest count, plus 1. No wrap-around inside a state.

Test Plan:
- Reset for 3 cycles, then release:
  - During reset, all outputs are 0.
  - The cycle after release: in_ready=1, busy=0.
- Accept 16'hA5C3 at defaults:
  - Bit sequence: 1111, 0, 1010010111000011, parity 0.
  - Each bit is 8 cycles; tx_bitclk is 0 for 4 cycles, then 1 for 4.
  - frame_done at accept+176; in_ready=1 at accept+193.
- Accept 16'h0001:
  - Parity bit = 1.
  - Encoder output (tx_data XOR tx_bitclk) for the last data bit reads 1 then 0.
- Hold in_valid high with changing data while busy:
  - Only the first word is transmitted.
  - The second word is accepted exactly when in_ready reasserts.
- Assert abort for 1 cycle in the middle of DATA:
  - Next cycle: tx_enable=0, busy=0, in_ready=1.
  - No frame_done pulse.
- Parameter sweep HALF_PERIOD=1, PREAMBLE_BITS=0, GAP_BITS=0, DATA_WIDTH=8, sending 8'h80:
  - Line sequence: 0, 10000000, 1.
  - frame_done at accept+20.
  - in_ready reasserts the following cycle.
